// File: rtl/char_rx_fifo_if.sv
// Character-receive bus: strobed character input, show-ahead valid/ready output,
// plus occupancy, accepted-character count, sticky overflow and match status.
interface char_rx_fifo_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [7:0]       i_data;
  logic             i_act;
  logic             i_ready;
  logic [7:0]       o_data;
  logic             o_valid;
  logic [LVL_W-1:0] o_level;
  logic [CNT_W-1:0] o_count;
  logic             o_overflow;
  logic             o_match;

  modport master (
    output i_data, i_act, i_ready,
    input  o_data, o_valid, o_level, o_count, o_overflow, o_match
  );

  modport slave (
    input  i_data, i_act, i_ready,
    output o_data, o_valid, o_level, o_count, o_overflow, o_match
  );
endinterface

// File: rtl/char_rx_fifo.sv
// Strobed character receiver with a small show-ahead FIFO, accepted-character counter
// and sticky overflow. Optional match pulse on MATCH_CHAR when CHAR_RX_MATCH_EN is defined.
module char_rx_fifo #(
  parameter int         DEPTH      = 4,
  parameter int         CNT_W      = 16,
  parameter logic [7:0] MATCH_CHAR = 8'd5
) (
  input logic            i_clock,
  input logic            i_reset_n,
  char_rx_fifo_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_p1, wr_ptr_p1, rd_next_p0;
  logic [LVL_W-1:0] level_p1;
  logic [CNT_W-1:0] count_p1;
  logic [7:0]       head_p1, head_nxt_p0;
  logic             overflow_p1;
  logic             empty_p0, full_p0, push_p0, pop_p0, drop_p0;

  // Stage p0: handshake decode from registered occupancy only.
  always_comb begin
    empty_p0   = (level_p1 == '0);
    full_p0    = (level_p1 == LVL_W'(DEPTH));
    pop_p0     = !empty_p0 && bus.i_ready;
    push_p0    = bus.i_act && (!full_p0 || pop_p0);
    drop_p0    = bus.i_act && full_p0 && !pop_p0;
    rd_next_p0 = rd_ptr_p1 + PTR_W'(1);
  end

  // Head register keeps o_data stable except on a pop or a push into an empty FIFO;
  // when more than one entry is held, the next head is already in storage.
  always_comb begin
    head_nxt_p0 = head_p1;
    if (push_p0 && empty_p0) begin
      head_nxt_p0 = bus.i_data;
    end else if (pop_p0) begin
      if (level_p1 > LVL_W'(1)) begin
        head_nxt_p0 = mem[rd_next_p0];
      end else if (push_p0) begin
        head_nxt_p0 = bus.i_data;
      end
    end
  end

  // Stage p1: storage (not reset) and control registers.
  always_ff @(posedge i_clock) begin
    if (push_p0) begin
      mem[wr_ptr_p1] <= bus.i_data;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr_p1   <= '0;
      wr_ptr_p1   <= '0;
      level_p1    <= '0;
      count_p1    <= '0;
      overflow_p1 <= 1'b0;
      head_p1     <= '0;
    end else begin
      head_p1 <= head_nxt_p0;
      if (push_p0) begin
        wr_ptr_p1 <= wr_ptr_p1 + PTR_W'(1);
        count_p1  <= count_p1 + CNT_W'(1);
      end
      if (pop_p0) begin
        rd_ptr_p1 <= rd_next_p0;
      end
      case ({push_p0, pop_p0})
        2'b10:   level_p1 <= level_p1 + LVL_W'(1);
        2'b01:   level_p1 <= level_p1 - LVL_W'(1);
        default: level_p1 <= level_p1;
      endcase
      if (drop_p0) begin
        overflow_p1 <= 1'b1;
      end
    end
  end

`ifdef CHAR_RX_MATCH_EN
  logic match_p1;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      match_p1 <= 1'b0;
    end else begin
      match_p1 <= push_p0 && (bus.i_data == MATCH_CHAR);
    end
  end

  assign bus.o_match = match_p1;
`else
  assign bus.o_match = 1'b0;
`endif

  assign bus.o_data     = head_p1;
  assign bus.o_valid    = !empty_p0;
  assign bus.o_level    = level_p1;
  assign bus.o_count    = count_p1;
  assign bus.o_overflow = overflow_p1;
endmodule

// File: doc/char_rx_fifo.md
Name: char_rx_fifo

Overview:
- Receiving end of the single-character strobe interface: captures each 8-bit character presented with a one-cycle activity strobe.
- Buffers captured characters in a small FIFO and hands them to a downstream reader over a valid/ready handshake.
- Keeps a running count of accepted characters and a sticky overflow flag.
- Sits directly behind any character source in the design that drives data plus a per-character strobe.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the accepted-character counter.
- MATCH_CHAR, 8'd5, character value compared when the optional match feature is compiled in.

Ports:
- i_clock  input  1  single clock; all state updates on its rising edge.
- i_reset_n  input  1  asynchronous active-low reset.
- i_data  input  8  character from the source; sampled only when i_act=1.
- i_act  input  1  source strobe; 1 means i_data holds a valid character this cycle.
- o_data  output  8  head-of-FIFO character (show-ahead).
- o_valid  output  1  FIFO non-empty; o_data is valid.
- i_ready  input  1  reader accepts o_data this cycle.
- o_level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_count  output  CNT_W  characters accepted into the FIFO since reset.
- o_overflow  output  1  sticky; set when a character is dropped.
- o_match  output  1  optional match pulse (see Optional Feature); tied 0 when not compiled in.

Behaviour:
- Reset: i_reset_n low clears asynchronously, independent of i_clock:
  - o_valid=0, o_data=0, o_level=0, o_count=0, o_overflow=0, o_match=0.
  - Read and write pointers = 0.
  - FIFO contents need not be cleared.
- Reset asserted mid-operation discards all buffered characters. First strobe sampled is at the first rising edge after i_reset_n deasserts.
- Push condition: i_act=1 at a rising edge, and the FIFO is either not full or a pop occurs in the same cycle.
- Pop condition: o_valid=1 and i_ready=1 at a rising edge. i_ready while o_valid=0 has no effect.
- Latency: a character strobed into an empty FIFO at edge N appears on o_data with o_valid=1 immediately after edge N. No combinational path from i_data/i_act to the outputs.
- o_data always reflects the entry at the read pointer. It changes only on a pop or on a push into an empty FIFO.
- o_level update rules:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop, including when full.
- Empty with simultaneous push and pop is not possible, since a pop requires o_valid=1.
- Full, i_act=1, no pop: character dropped, o_overflow set to 1 and held until reset. o_count and the FIFO are unchanged.
- Full, i_act=1, pop in the same cycle: push accepted, o_level stays DEPTH, no overflow.
- o_count increments by 1 per accepted push, modulo 2^CNT_W (0xFFFF+1 -> 0x0000 at CNT_W=16). Dropped characters are not counted.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty is derived from o_level.
- The source drives i_act as a clean single-cycle strobe. Back-to-back strobes on consecutive cycles are legal, and each is a separate character.
- i_data is ignored whenever i_act=0.

Optional Feature:
- Macro: CHAR_RX_MATCH_EN.
- Defined: o_match is a registered one-cycle pulse, high in the cycle after any accepted push whose character equals MATCH_CHAR. Dropped characters never match. Reset value 0.
- Undefined: no comparator logic is built and o_match is constant 0.
- All other behaviour is identical in both builds.

Test Plan:
- Periodic source: DEPTH=4, i_act=1 with i_data=0x05 every 8th cycle, i_ready=1. Required response:
  - o_valid pulses high for 1 cycle after each strobe, with o_data=0x05.
  - o_level never exceeds 1; o_count=3 after 3 strobes; o_overflow=0.
  - With CHAR_RX_MATCH_EN and MATCH_CHAR=5: o_match pulses once per strobe.
- Fill and overflow: i_ready=0; push 0x11, 0x22, 0x33, 0x44, 0x55 on consecutive cycles. Required response:
  - o_level=4 and o_count=4.
  - o_overflow=1 after the 5th push and stays 1.
  - Draining with i_ready=1 yields 0x11, 0x22, 0x33, 0x44, then o_valid=0.
- Full with simultaneous push/pop: fill with 0xA0..0xA3, then i_act=1 with 0xA4 and i_ready=1 in the same cycle. Required response:
  - o_level stays 4 and o_overflow stays 0.
  - Drain order is 0xA1, 0xA2, 0xA3, 0xA4.
- Counter wrap: CNT_W=4; push 17 characters with i_ready=1. Required response: o_count reads 0x1 and o_overflow=0.
- Async reset mid-operation: 3 characters buffered; pull i_reset_n low between clock edges. Required response:
  - o_valid, o_level, o_count and o_overflow drop to 0 before the next edge.
  - After release, a new push of 0x7E is the first character read out.
- Match filtering (CHAR_RX_MATCH_EN, MATCH_CHAR=8'h05): push 0x04, 0x05, 0x06 with i_ready=1. Required response:
  - Exactly one o_match pulse, in the cycle after 0x05 is accepted.
  - Without the macro, o_match stays 0 throughout.
